// File: rtl/pc_next_if.sv
// ============================================================================
// Module      : pc_next_if
// Description : Control and address bundle between branch-resolve logic and
//               the program-counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_next_if #(
    parameter int PC_W = 10
);
    logic            stall;
    logic            exc;
    logic [PC_W-1:0] pc_exc;
    logic [1:0]      dir_sl;
    logic            link;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] pc_jump;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] pc_next;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    modport master (
        output stall, exc, pc_exc, dir_sl, link, pc_branch, pc_jump,
        input  pc_out, pc_next, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, exc, pc_exc, dir_sl, link, pc_branch, pc_jump,
        output pc_out, pc_next, ras_empty, ras_full, ras_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================================
// Module      : pc_next_unit
// Description : PC register with next-address selection, stall hold and a
//               circular return-address stack for call/return prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_unit #(
    parameter int PC_W      = 10,
    parameter int INC       = 1,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_next_if.slave  bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] c_DIR_SEQ    = 2'b00;
    localparam logic [1:0] c_DIR_BRANCH = 2'b01;
    localparam logic [1:0] c_DIR_JUMP   = 2'b10;
    localparam logic [1:0] c_DIR_RET    = 2'b11;

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [PC_W-1:0]  w_seq;
    logic [PC_W-1:0]  w_next;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_err;

    assign w_seq     = r_pc + PC_W'(INC);
    assign w_ptr_inc = r_ptr + PTR_W'(1);
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));

    // Selection doubles as the PC register's D input, so pc_next is exact.
    always_comb begin
        w_next = r_pc;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_err  = 1'b0;
        if (rst) begin
            w_next = PC_W'(RESET_PC);
        end else if (bus.exc) begin
            w_next = bus.pc_exc;
        end else if (!bus.stall) begin
            case (bus.dir_sl)
                c_DIR_SEQ:    w_next = w_seq;
                c_DIR_BRANCH: w_next = bus.pc_branch;
                c_DIR_JUMP: begin
                    w_next = bus.pc_jump;
                    w_push = bus.link;
                    w_err  = bus.link & w_full;
                end
                c_DIR_RET: begin
                    if (w_empty) begin
                        w_next = w_seq;
                        w_err  = 1'b1;
                    end else begin
                        w_next = r_ras[r_ptr];
                        w_pop  = 1'b1;
                    end
                end
                default: w_next = w_seq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= PC_W'(RESET_PC);
            r_ptr <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_next;
            r_err <= w_err;
            if (bus.exc) begin
                r_ptr <= '0;
                r_cnt <= '0;
            end else if (w_push) begin
                // A push when full overwrites the oldest slot; count saturates.
                r_ptr <= w_ptr_inc;
                if (!w_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr <= r_ptr - PTR_W'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; validity is tracked solely by r_cnt.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ras[w_ptr_inc] <= w_seq;
        end
    end

    assign bus.pc_out    = r_pc;
    assign bus.pc_next   = w_next;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
    assign bus.ras_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// Module      : tb_pc_next_unit
// Description : Directed vector table plus randomized run against a
//               queue-based return-stack reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_next_unit;
    localparam int PC_W      = 10;
    localparam int INC       = 1;
    localparam int RESET_PC  = 'h3FE;
    localparam int RAS_DEPTH = 4;
    localparam int N_VEC     = 28;
    localparam int N_RAND    = 3000;

    typedef struct {
        logic            rst;
        logic            exc;
        logic            stall;
        logic [1:0]      dir;
        logic            link;
        logic [PC_W-1:0] pexc;
        logic [PC_W-1:0] pbr;
        logic [PC_W-1:0] pj;
        logic [PC_W-1:0] exp_pc;
        logic            exp_empty;
        logic            exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Reference model state: PC, stack of return addresses (back = top), err.
    int   m_pc;
    int   m_q[$];
    int   m_err;

    vec_t vt[N_VEC];

    pc_next_if #(.PC_W(PC_W)) bus ();

    pc_next_unit #(
        .PC_W      (PC_W),
        .INC       (INC),
        .RESET_PC  (RESET_PC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the reference model by one cycle and returns the next PC.
    function automatic int model_step(input logic r, e, s, input logic [1:0] d,
                                      input logic l, input int pe, pb, pj);
        int seq;
        int npc;
        seq   = (m_pc + INC) % (1 << PC_W);
        npc   = m_pc;
        m_err = 0;
        if (r) begin
            npc = RESET_PC;
            m_q.delete();
        end else if (e) begin
            npc = pe;
            m_q.delete();
        end else if (!s) begin
            case (d)
                2'd0: npc = seq;
                2'd1: npc = pb;
                2'd2: begin
                    npc = pj;
                    if (l) begin
                        if (m_q.size() == RAS_DEPTH) begin
                            void'(m_q.pop_front());
                            m_err = 1;
                        end
                        m_q.push_back(seq);
                    end
                end
                default: begin
                    if (m_q.size() > 0) begin
                        npc = m_q.pop_back();
                    end else begin
                        npc   = seq;
                        m_err = 1;
                    end
                end
            endcase
        end
        m_pc = npc;
        return npc;
    endfunction

    task automatic step(input logic r, e, s, input logic [1:0] d, input logic l,
                        input logic [PC_W-1:0] pe, pb, pj);
        int npc;
        @(negedge clk);
        rst           = r;
        bus.exc       = e;
        bus.stall     = s;
        bus.dir_sl    = d;
        bus.link      = l;
        bus.pc_exc    = pe;
        bus.pc_branch = pb;
        bus.pc_jump   = pj;
        #1;
        npc = model_step(r, e, s, d, l, int'(pe), int'(pb), int'(pj));
        chk("pc_next", int'(bus.pc_next), npc);
        @(posedge clk);
        #1;
        chk("pc_out", int'(bus.pc_out), m_pc);
        chk("ras_empty", int'(bus.ras_empty), int'(m_q.size() == 0));
        chk("ras_full", int'(bus.ras_full), int'(m_q.size() == RAS_DEPTH));
        chk("ras_err", int'(bus.ras_err), m_err);
    endtask

    function automatic vec_t mk(input logic r, e, s, input logic [1:0] d, input logic l,
                                input logic [PC_W-1:0] pe, pb, pj, epc,
                                input logic eempty, eerr);
        vec_t v;
        v.rst = r; v.exc = e; v.stall = s; v.dir = d; v.link = l;
        v.pexc = pe; v.pbr = pb; v.pj = pj;
        v.exp_pc = epc; v.exp_empty = eempty; v.exp_err = eerr;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_pc     = RESET_PC;
        m_err    = 0;
        rst           = 1'b1;
        bus.exc       = 1'b0;
        bus.stall     = 1'b0;
        bus.dir_sl    = 2'd0;
        bus.link      = 1'b0;
        bus.pc_exc    = '0;
        bus.pc_branch = '0;
        bus.pc_jump   = '0;

        //            rst exc stl dir lnk pexc    pbr     pj      exp_pc  emp err
        vt[0]  = mk(1, 0, 0, 2'd0, 0, 10'h000, 10'h000, 10'h000, 10'h3FE, 1, 0);
        vt[1]  = mk(0, 0, 0, 2'd0, 0, 10'h000, 10'h000, 10'h000, 10'h3FF, 1, 0);
        vt[2]  = mk(0, 0, 0, 2'd0, 0, 10'h000, 10'h000, 10'h000, 10'h000, 1, 0);
        vt[3]  = mk(0, 0, 0, 2'd0, 0, 10'h000, 10'h000, 10'h000, 10'h001, 1, 0);
        vt[4]  = mk(0, 0, 0, 2'd2, 0, 10'h000, 10'h000, 10'h010, 10'h010, 1, 0);
        vt[5]  = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h200, 10'h200, 0, 0);
        vt[6]  = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h011, 1, 0);
        vt[7]  = mk(0, 0, 0, 2'd2, 0, 10'h000, 10'h000, 10'h010, 10'h010, 1, 0);
        vt[8]  = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h020, 10'h020, 0, 0);
        vt[9]  = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h030, 10'h030, 0, 0);
        vt[10] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h040, 10'h040, 0, 0);
        vt[11] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h050, 10'h050, 0, 0);
        vt[12] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h300, 10'h300, 0, 1);
        vt[13] = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h051, 0, 0);
        vt[14] = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h041, 0, 0);
        vt[15] = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h031, 0, 0);
        vt[16] = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h021, 1, 0);
        vt[17] = mk(0, 0, 0, 2'd3, 0, 10'h000, 10'h000, 10'h000, 10'h022, 1, 1);
        vt[18] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h100, 10'h100, 0, 0);
        vt[19] = mk(0, 0, 1, 2'd1, 0, 10'h000, 10'h123, 10'h000, 10'h100, 0, 0);
        vt[20] = mk(0, 0, 1, 2'd1, 0, 10'h000, 10'h123, 10'h000, 10'h100, 0, 0);
        vt[21] = mk(0, 0, 1, 2'd1, 0, 10'h000, 10'h123, 10'h000, 10'h100, 0, 0);
        vt[22] = mk(0, 0, 0, 2'd1, 0, 10'h000, 10'h123, 10'h000, 10'h123, 0, 0);
        vt[23] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h150, 10'h150, 0, 0);
        vt[24] = mk(0, 1, 1, 2'd3, 0, 10'h080, 10'h000, 10'h000, 10'h080, 1, 0);
        vt[25] = mk(0, 0, 0, 2'd2, 1, 10'h000, 10'h000, 10'h060, 10'h060, 0, 0);
        vt[26] = mk(1, 1, 0, 2'd2, 1, 10'h077, 10'h000, 10'h0AA, 10'h3FE, 1, 0);
        vt[27] = mk(0, 0, 0, 2'd0, 0, 10'h000, 10'h000, 10'h000, 10'h3FF, 1, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < N_VEC; i++) begin
            step(vt[i].rst, vt[i].exc, vt[i].stall, vt[i].dir, vt[i].link,
                 vt[i].pexc, vt[i].pbr, vt[i].pj);
            chk($sformatf("vec%0d pc_out", i), int'(bus.pc_out), int'(vt[i].exp_pc));
            chk($sformatf("vec%0d ras_empty", i), int'(bus.ras_empty), int'(vt[i].exp_empty));
            chk($sformatf("vec%0d ras_err", i), int'(bus.ras_err), int'(vt[i].exp_err));
        end

        // Randomized traffic; calls and returns are biased up to exercise the stack.
        for (int i = 0; i < N_RAND; i++) begin
            logic            r, e, s, l;
            logic [1:0]      d;
            logic [PC_W-1:0] pe, pb, pj;
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 29) == 0);
            s  = ($urandom_range(0, 7) == 0);
            d  = 2'($urandom_range(0, 3));
            l  = ($urandom_range(0, 3) != 0);
            pe = PC_W'($urandom);
            pb = PC_W'($urandom);
            pj = PC_W'($urandom);
            step(r, e, s, d, l, pe, pb, pj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
